// File: rtl/activity_monitor.sv
// Saturating CPU activity counters with a single-entry snapshot; counts visible 1 cycle after the event.
// No backpressure: a snapshot is held until snap_ack, and snap_req while one is held is dropped.
module activity_monitor #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [STATE_W-1:0] fsm_state,
    input  logic               pc_write,
    input  logic               recovery_active,
    input  logic               snap_req,
    input  logic               snap_ack,
    output logic [CNT_W-1:0]   fsm_transition_count,
    output logic [CNT_W-1:0]   pcwrite_toggle_count,
    output logic [CNT_W-1:0]   recovery_cycle_count,
    output logic [CNT_W-1:0]   enabled_cycle_count,
    output logic [CNT_W-1:0]   snap_fsm,
    output logic [CNT_W-1:0]   snap_pcw,
    output logic [CNT_W-1:0]   snap_rec,
    output logic [CNT_W-1:0]   snap_cyc,
    output logic               snap_valid,
    output logic [3:0]         sat_flags
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0] prev_state;
    logic               prev_pcw;
    logic               primed;

    logic               fsm_inc;
    logic               pcw_inc;
    logic               rec_inc;
    logic               cyc_inc;
    logic               capture;
    logic [CNT_W-1:0]   fsm_nxt;
    logic [CNT_W-1:0]   pcw_nxt;
    logic [CNT_W-1:0]   rec_nxt;
    logic [CNT_W-1:0]   cyc_nxt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic inc);
        return (inc && (cnt != CNT_MAX)) ? cnt + CNT_ONE : cnt;
    endfunction

    // Edge detection is suppressed until prev_* hold a real sample.
    always_comb begin
        fsm_inc = enable && primed && (fsm_state != prev_state);
        pcw_inc = enable && primed && (pc_write != prev_pcw);
        rec_inc = enable && recovery_active;
        cyc_inc = enable;
        capture = snap_req && !snap_valid;
        fsm_nxt = sat_add(fsm_transition_count, fsm_inc);
        pcw_nxt = sat_add(pcwrite_toggle_count, pcw_inc);
        rec_nxt = sat_add(recovery_cycle_count, rec_inc);
        cyc_nxt = sat_add(enabled_cycle_count, cyc_inc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_state           <= '0;
            prev_pcw             <= 1'b0;
            primed               <= 1'b0;
            fsm_transition_count <= '0;
            pcwrite_toggle_count <= '0;
            recovery_cycle_count <= '0;
            enabled_cycle_count  <= '0;
            sat_flags            <= '0;
            snap_fsm             <= '0;
            snap_pcw             <= '0;
            snap_rec             <= '0;
            snap_cyc             <= '0;
            snap_valid           <= 1'b0;
        end else begin
            prev_state <= fsm_state;
            prev_pcw   <= pc_write;
            primed     <= 1'b1;

            if (clear) begin
                fsm_transition_count <= '0;
                pcwrite_toggle_count <= '0;
                recovery_cycle_count <= '0;
                enabled_cycle_count  <= '0;
                sat_flags            <= '0;
            end else begin
                fsm_transition_count <= fsm_nxt;
                pcwrite_toggle_count <= pcw_nxt;
                recovery_cycle_count <= rec_nxt;
                enabled_cycle_count  <= cyc_nxt;
                sat_flags            <= sat_flags | {cyc_nxt == CNT_MAX, rec_nxt == CNT_MAX,
                                                     pcw_nxt == CNT_MAX, fsm_nxt == CNT_MAX};
            end

            // Snapshot takes the registered values, so a same-cycle clear gives read-and-clear.
            if (capture) begin
                snap_fsm   <= fsm_transition_count;
                snap_pcw   <= pcwrite_toggle_count;
                snap_rec   <= recovery_cycle_count;
                snap_cyc   <= enabled_cycle_count;
                snap_valid <= 1'b1;
            end else if (snap_valid && snap_ack) begin
                snap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_activity_monitor.sv
// Directed stimulus with a cycle-stamped scoreboard; a negedge monitor compares queued expectations.
module tb_activity_monitor;

    localparam int S_FSM  = 0;
    localparam int S_PCW  = 1;
    localparam int S_REC  = 2;
    localparam int S_CYC  = 3;
    localparam int S_SFSM = 4;
    localparam int S_SPCW = 5;
    localparam int S_SREC = 6;
    localparam int S_SCYC = 7;
    localparam int S_SVLD = 8;
    localparam int S_SAT  = 9;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [3:0]  fsm_state;
    logic        pc_write;
    logic        recovery_active;
    logic        snap_req;
    logic        snap_ack;
    logic [31:0] fsm_transition_count;
    logic [31:0] pcwrite_toggle_count;
    logic [31:0] recovery_cycle_count;
    logic [31:0] enabled_cycle_count;
    logic [31:0] snap_fsm;
    logic [31:0] snap_pcw;
    logic [31:0] snap_rec;
    logic [31:0] snap_cyc;
    logic        snap_valid;
    logic [3:0]  sat_flags;

    int   cyc_num = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sbq[$];
    string nm [10] = '{"fsm_cnt", "pcw_cnt", "rec_cnt", "cyc_cnt", "snap_fsm",
                       "snap_pcw", "snap_rec", "snap_cyc", "snap_valid", "sat_flags"};

    activity_monitor #(.STATE_W(4), .CNT_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .clear                (clear),
        .fsm_state            (fsm_state),
        .pc_write             (pc_write),
        .recovery_active      (recovery_active),
        .snap_req             (snap_req),
        .snap_ack             (snap_ack),
        .fsm_transition_count (fsm_transition_count),
        .pcwrite_toggle_count (pcwrite_toggle_count),
        .recovery_cycle_count (recovery_cycle_count),
        .enabled_cycle_count  (enabled_cycle_count),
        .snap_fsm             (snap_fsm),
        .snap_pcw             (snap_pcw),
        .snap_rec             (snap_rec),
        .snap_cyc             (snap_cyc),
        .snap_valid           (snap_valid),
        .sat_flags            (sat_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_num <= cyc_num + 1;

    function automatic logic [31:0] dut_val(input int sel);
        case (sel)
            S_FSM:   return fsm_transition_count;
            S_PCW:   return pcwrite_toggle_count;
            S_REC:   return recovery_cycle_count;
            S_CYC:   return enabled_cycle_count;
            S_SFSM:  return snap_fsm;
            S_SPCW:  return snap_pcw;
            S_SREC:  return snap_rec;
            S_SCYC:  return snap_cyc;
            S_SVLD:  return {31'd0, snap_valid};
            default: return {28'd0, sat_flags};
        endcase
    endfunction

    // Expectation for the DUT state after the next rising edge.
    task automatic expect_v(input int sel, input logic [31:0] val);
        exp_t e;
        e.due = cyc_num + 1;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic expect_all_zero();
        for (int i = 0; i < 10; i++) expect_v(i, 32'd0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0 && sbq[0].due <= cyc_num) begin
            e   = sbq.pop_front();
            act = dut_val(e.sel);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h want %h", nm[e.sel], cyc_num, act, e.val);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; fsm_state = 4'd0; pc_write = 1'b0;
        recovery_active = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;

        // Reset state
        expect_all_zero();
        step();
        step();

        // Priming cycle with inputs differing from reset value of prev_*: nothing counted
        reset = 1'b0; enable = 1'b1; fsm_state = 4'd5; pc_write = 1'b1;
        expect_v(S_FSM, 32'd0); expect_v(S_PCW, 32'd0); expect_v(S_CYC, 32'd1);
        step();
        enable = 1'b0; fsm_state = 4'd0; pc_write = 1'b0; clear = 1'b1;
        expect_v(S_CYC, 32'd0);
        step();
        clear = 1'b0;
        step();

        // FSM sequence 0,1,1,2,0 -> 3 transitions over 5 enabled cycles
        enable = 1'b1;
        begin
            logic [3:0]  seq   [5] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd0};
            logic [31:0] exp_t_[5] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
            for (int i = 0; i < 5; i++) begin
                fsm_state = seq[i];
                expect_v(S_FSM, exp_t_[i]);
                expect_v(S_CYC, 32'(i + 1));
                step();
            end
        end
        expect_v(S_PCW, 32'd0);

        // pc_write 0,1,0,1 enabled -> 3 toggles, then disabled -> 0
        enable = 1'b0; clear = 1'b1;
        expect_v(S_FSM, 32'd0); expect_v(S_CYC, 32'd0);
        step();
        clear = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_write = i[0];
            expect_v(S_PCW, 32'(i));
            step();
        end
        enable = 1'b0; clear = 1'b1;
        expect_v(S_PCW, 32'd0);
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_write = i[0];
            expect_v(S_PCW, 32'd0);
            expect_v(S_CYC, 32'd0);
            step();
        end

        // 7 recovery cycles with enable low for 2 -> 5
        recovery_active = 1'b1;
        begin
            logic        en_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            logic [31:0] rec_ex[7] = '{32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd4, 32'd5};
            for (int i = 0; i < 7; i++) begin
                enable = en_pat[i];
                expect_v(S_REC, rec_ex[i]);
                step();
            end
        end
        expect_v(S_CYC, 32'd5);
        expect_v(S_PCW, 32'd0);
        enable = 1'b0; recovery_active = 1'b0;
        step();

        // Saturation of the recovery counter, then clear
        force dut.recovery_cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.recovery_cycle_count;
        enable = 1'b1; recovery_active = 1'b1;
        expect_v(S_REC, 32'hFFFF_FFFF); expect_v(S_SAT, 32'h4);
        step();
        expect_v(S_REC, 32'hFFFF_FFFF);
        step();
        expect_v(S_REC, 32'hFFFF_FFFF); expect_v(S_SAT, 32'h4); expect_v(S_CYC, 32'd8);
        step();
        clear = 1'b1;
        expect_v(S_REC, 32'd0); expect_v(S_SAT, 32'd0); expect_v(S_CYC, 32'd0);
        step();
        clear = 1'b0; recovery_active = 1'b0;

        // Reach fsm count 10, then atomic snapshot-and-clear
        for (int i = 0; i < 10; i++) begin
            fsm_state = (i % 2 == 0) ? 4'd1 : 4'd0;
            step();
        end
        snap_req = 1'b1; clear = 1'b1; fsm_state = 4'd1;
        expect_v(S_SFSM, 32'd10); expect_v(S_SCYC, 32'd10); expect_v(S_SPCW, 32'd0);
        expect_v(S_SREC, 32'd0);  expect_v(S_FSM, 32'd0);   expect_v(S_CYC, 32'd0);
        expect_v(S_SVLD, 32'd1);
        step();
        clear = 1'b0; fsm_state = 4'd0;
        expect_v(S_FSM, 32'd1); expect_v(S_SFSM, 32'd10); expect_v(S_SCYC, 32'd10);
        expect_v(S_SVLD, 32'd1);
        step();
        snap_ack = 1'b1;
        expect_v(S_SVLD, 32'd0); expect_v(S_SFSM, 32'd10); expect_v(S_CYC, 32'd2);
        step();
        snap_req = 1'b0; snap_ack = 1'b0;
        expect_v(S_SVLD, 32'd0);
        step();
        snap_ack = 1'b1;
        expect_v(S_SVLD, 32'd0);
        step();
        snap_ack = 1'b0; snap_req = 1'b1; fsm_state = 4'd1;
        expect_v(S_SFSM, 32'd1); expect_v(S_SCYC, 32'd4); expect_v(S_FSM, 32'd2);
        expect_v(S_CYC, 32'd5);  expect_v(S_SVLD, 32'd1);
        step();

        // Reset overrides a held snapshot and same-cycle clear/snap_req
        reset = 1'b1; clear = 1'b1; snap_req = 1'b1; fsm_state = 4'd1;
        expect_all_zero();
        step();
        reset = 1'b0; clear = 1'b0; snap_req = 1'b0;
        fsm_state = 4'd2; pc_write = 1'b1; recovery_active = 1'b1;
        expect_v(S_FSM, 32'd0); expect_v(S_PCW, 32'd0); expect_v(S_REC, 32'd1);
        expect_v(S_CYC, 32'd1); expect_v(S_SVLD, 32'd0);
        step();
        fsm_state = 4'd3; pc_write = 1'b0;
        expect_v(S_FSM, 32'd1); expect_v(S_PCW, 32'd1); expect_v(S_CYC, 32'd2);
        step();
        step();
        step();

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/activity_monitor.md
ACTIVITY_MONITOR -- requirements
Module: activity_monitor

Interface
REQ-001 Parameter STATE_W, default 4, width of the observed CPU FSM state encoding.
REQ-002 Parameter CNT_W, fixed value 32, width of every activity counter.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  counting enable; when low, no counter increments.
REQ-006 clear  input  1  synchronous clear of all live counters and saturation flags.
REQ-007 fsm_state  input  STATE_W  current CPU control FSM state.
REQ-008 pc_write  input  1  CPU PCWrite control signal.
REQ-009 recovery_active  input  1  high on every cycle the CPU spends in fault recovery.
REQ-010 snap_req  input  1  request to capture the live counters.
REQ-011 snap_ack  input  1  consumer acknowledge of a held snapshot.
REQ-012 fsm_transition_count  output  32  live count of FSM state changes.
REQ-013 pcwrite_toggle_count  output  32  live count of pc_write level changes.
REQ-014 recovery_cycle_count  output  32  live count of recovery cycles.
REQ-015 enabled_cycle_count  output  32  live count of enabled cycles.
REQ-016 snap_fsm, snap_pcw, snap_rec, snap_cyc  output  32 each  snapshot copies of the four live counters.
REQ-017 snap_valid  output  1  snapshot held and unacknowledged.
REQ-018 sat_flags  output  4  sticky saturation flags; bit order [3]=cyc, [2]=rec, [1]=pcw, [0]=fsm.

Function
REQ-019 Registers prev_state and prev_pcw shall load fsm_state and pc_write on every non-reset cycle, regardless of enable and clear.
REQ-020 A primed flag shall clear on reset and set on the first non-reset cycle; while primed is 0, no transition and no toggle shall be counted.
REQ-021 fsm_transition_count shall increment by 1 when enable, primed, and fsm_state != prev_state all hold.
REQ-022 pcwrite_toggle_count shall increment by 1 when enable, primed, and pc_write != prev_pcw all hold; rising and falling edges each count once.
REQ-023 recovery_cycle_count shall increment by 1 on each cycle with enable and recovery_active both high.
REQ-024 enabled_cycle_count shall increment by 1 on each cycle with enable high.
REQ-025 Updated live counter values shall be visible at the outputs one cycle after the qualifying event.
REQ-026 Each counter shall saturate at 32'hFFFF_FFFF and never wrap.
REQ-027 A counter's sat_flags bit shall set on the cycle the counter reaches 32'hFFFF_FFFF; the bit stays set until clear or reset.
REQ-028 When clear is high, all live counters and sat_flags shall be 0 on the next cycle; clear overrides any increment in that cycle.
REQ-029 Snapshot capture condition: snap_req high with snap_valid low.
REQ-030 On capture, snap_* shall load the pre-update live register values (the current-cycle event is excluded), and snap_valid shall be 1 on the next cycle.
REQ-031 Capture and clear in the same cycle shall form an atomic read-and-clear: the snapshot gets the pre-clear values and the live counters become 0.
REQ-032 snap_valid and the snap_* values shall hold stable until a cycle with snap_ack high; snap_valid shall be 0 on the following cycle.
REQ-033 snap_req while snap_valid is high shall be ignored and not queued, including in a cycle that also has snap_ack high.
REQ-034 snap_ack while snap_valid is low shall have no effect.
REQ-035 Snapshot logic shall be unaffected by enable.

Reset
REQ-036 On reset, all live counters, snap_* outputs, sat_flags, snap_valid, primed, prev_state, and prev_pcw shall be 0 on the next cycle.
REQ-037 Reset shall override clear, snap_req, and snap_ack in the same cycle; a held snapshot is discarded.
REQ-038 The first cycle after reset deasserts shall count no transition or toggle, even if fsm_state or pc_write differ from 0.

Verification
REQ-039 Scenario: enable=1; fsm_state sequence 0,1,1,2,0 after priming -> fsm_transition_count=3 and enabled_cycle_count=5.
REQ-040 Scenario: pc_write pattern 0,1,0,1 with enable=1 -> pcwrite_toggle_count=3; same pattern with enable=0 -> count stays 0.
REQ-041 Scenario: recovery_active high for 7 cycles, with enable low for 2 of them -> recovery_cycle_count=5.
REQ-042 Scenario: recovery counter forced to 32'hFFFF_FFFE, then 3 recovery cycles -> count=32'hFFFF_FFFF and sat_flags[2]=1; then clear -> count=0 and sat_flags=0.
REQ-043 Scenario: live fsm count 10, snap_req and clear together -> next cycle snap_fsm=10, fsm_transition_count=0, snap_valid=1; a second snap_req while valid is ignored; snap_ack -> snap_valid=0.
REQ-044 Scenario: reset asserted while snap_valid=1 and counters nonzero -> all outputs 0 next cycle; first post-reset state change is not counted.
